data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
// - Initiator between pipeline MEM stage and 256x32 word-addressed data RAM (Enable/ReadWrite/Address/DataIn/DataOut).
// - Byte address in, word index out. Byte/halfword/word loads (sign/zero extend); sub-word stores via read-modify-write.
// - Stalls pipeline while an access is in flight. Little-endian: byte lane 0 = bits[7:0].
// PARAMETERS
// - RD_LAT  1  cycles ram_enable held high (read) before ram_rdata sampled; legal 1..4
// - ADDR_W  8  word-index bits driven on ram_addr; RAM depth = 2**ADDR_W words
// PORTS
// - clk         in   1   single clock, rising edge
// - reset       in   1   asynchronous, active-high
// - req_valid   in   1   MEM-stage access request; held stable while stall=1
// - req_write   in   1   1=store, 0=load
// - req_size    in   2   00 byte, 01 halfword, 10 word (11 treated as word)
// - req_signed  in   1   loads: 1=sign-extend, 0=zero-extend
// - req_addr    in   32  byte address
// - req_wdata   in   32  store data, right-justified
// - stall       out  1   combinational: (IDLE & req_valid) | (state not IDLE/RESP)
// - rsp_valid   out  1   one-cycle pulse, access complete
// - rsp_rdata   out  32  extended load data; valid with rsp_valid, held until next load completes
// - rsp_err     out  1   misaligned access flag, valid with rsp_valid
// - ram_enable  out  1   RAM Enable
// - ram_rw      out  1   RAM ReadWrite: 1=read, 0=write
// - ram_addr    out  32  {zeros, req_addr[ADDR_W+1:2]}
// - ram_wdata   out  32  RAM DataIn
// - ram_rdata   in   32  RAM DataOut
// BEHAVIOUR
// - Reset (async): state IDLE; ram_enable=0, ram_rw=1, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
// - Request latched in IDLE when req_valid=1; inputs ignored in all other states.
// - RAM is edge-sensitive on Enable/ReadWrite: addr, rw, wdata change only while ram_enable=0; ram_enable low >=1 cycle between accesses.
// - States (all registered outputs):
//   IDLE -> SETUP (or ERR if misaligned).
//   SETUP: enable=0, drive addr; rw=1 for load or sub-word store, rw=0 + wdata for word store. -> RD (rw=1) / WR.
//   RD: enable=1, rw=1 for RD_LAT cycles; sample ram_rdata on last. -> RESP (load) / MERGE (sub-word store).
//   MERGE: enable=0; replace addressed byte/half lane with req_wdata[7:0]/[15:0]; drive wdata, rw=0. -> WR.
//   WR: enable=1, rw=0, one cycle. -> RESP.
//   RESP: enable=0, rw=1, rsp_valid=1; load: rsp_rdata = lane extracted+extended. -> IDLE.
//   ERR: no RAM activity, rsp_valid=1, rsp_err=1, rsp_rdata unchanged. -> IDLE.
// - Latency (acceptance edge = cycle 0, rsp_valid cycle): load 2+RD_LAT; word store 3; sub-word store 4+RD_LAT; error 1.
// - Lane select: byte addr[1:0]; halfword addr[1] (0 -> bits[15:0]).
// - Address bits above ADDR_W+1 ignored (wrap modulo RAM depth).
// - Reset mid-access: immediate IDLE, enable dropped; store interrupted in WR may or may not have updated RAM; no rsp_valid.
// - Back-to-back: new request accepted earliest the cycle after RESP (IDLE).
// CONFIGURATION
// - MEMCTRL_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 -> ERR state, RAM untouched.
// - Undefined: misaligned low bits forced to zero (aligned access proceeds normally); ERR unreachable; rsp_err tied 0.
// TESTING (RD_LAT=1, RAM word 5 preloaded 0x887766F4)
// - Word load addr 0x14 at cycle 0 -> enable high cycle 2 only, rsp_valid cycle 3, rsp_rdata=0x887766F4, stall low in cycle 3.
// - Byte loads addr 0x14 signed -> 0xFFFFFFF4; unsigned -> 0x000000F4; addr 0x16 signed -> 0x00000077.
// - Halfword signed load addr 0x16 -> 0xFFFF8877; word store 0xDEADBEEF @0x20 -> one write cycle, rsp cycle 3, RAM[8]=0xDEADBEEF.
// - Byte store 0xAB @0x15 over 0x887766F4 -> RAM[5]=0x8877ABF4, rsp_valid cycle 5, enable low between RD and WR.
// - With MEMCTRL_MISALIGN_TRAP_EN: word load @0x15 -> rsp_valid+rsp_err cycle 1, ram_enable never high; without: reads RAM[5].
// - Reset asserted during RD of a load -> outputs at reset values same cycle, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                   |
// | Purpose  : Bridges the pipeline MEM stage to a word-addressed data RAM.    |
// |            Takes a byte address and sends a word index to the RAM.         |
// |            Loads come back byte, halfword or word wide, sign- or zero-     |
// |            extended. Sub-word stores use read-modify-write. The pipeline   |
// |            is stalled while an access is in flight. Byte order is little-  |
// |            endian, so byte lane 0 is bits [7:0].                           |
// | Ports    : clk, reset (async, active-high)                                 |
// |            req_valid/req_write/req_size/req_signed/req_addr/req_wdata :    |
// |              request from the MEM stage                                    |
// |            stall : combinational pipeline hold                             |
// |            rsp_valid/rsp_rdata/rsp_err : completion pulse, load data and   |
// |              misalignment flag                                             |
// |            ram_enable/ram_rw/ram_addr/ram_wdata/ram_rdata : RAM port       |
// |              (ram_rw 1=read, 0=write)                                      |
// | Config   : define MEMCTRL_MISALIGN_TRAP_EN to report misaligned halfword   |
// |            and word accesses through rsp_err, leaving the RAM untouched.   |
// |            When it is undefined, misaligned low address bits are ignored.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_ctrl #(
    parameter int RD_LAT = 1,   // cycles enable is held for a read, 1..4
    parameter int ADDR_W = 8    // word-index width, RAM depth = 2**ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_RD    = 3'd2;
    localparam logic [2:0] c_ST_MERGE = 3'd3;
    localparam logic [2:0] c_ST_WR    = 3'd4;
    localparam logic [2:0] c_ST_RESP  = 3'd5;
    localparam logic [2:0] c_ST_ERR   = 3'd6;

    localparam logic [2:0] c_LAT_INIT = 3'(RD_LAT - 1);

    logic [2:0]  r_state, w_nxt_state;
    logic [2:0]  r_lat_cnt, w_nxt_cnt;
    logic        r_write, r_signed;
    logic [1:0]  r_size, r_lane;
    logic [15:0] r_wdata_lo;
    logic        r_ram_enable, w_nxt_en;
    logic        r_ram_rw, w_nxt_rw;
    logic [31:0] r_ram_addr, w_nxt_addr;
    logic [31:0] r_ram_wdata, w_nxt_wdata;
    logic        r_rsp_valid, w_nxt_rsp_valid;
    logic        r_rsp_err, w_nxt_rsp_err;
    logic [31:0] r_rsp_rdata, w_nxt_rsp_rdata;
    logic        w_misalign;
    logic        w_accept;
    logic        w_unused;

`ifdef MEMCTRL_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'b01) & req_addr[0]) |
                        (req_size[1] & (req_addr[1:0] != 2'b00));
`else
    // Low address bits are dropped by lane selection, so a misaligned
    // access simply becomes the aligned one.
    assign w_misalign = 1'b0;
`endif

    // Address bits above the RAM depth wrap silently.
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};
    assign w_accept = (r_state == c_ST_IDLE) & req_valid;

    assign stall      = w_accept | ((r_state != c_ST_IDLE) & (r_state != c_ST_RESP));
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign ram_enable = r_ram_enable;
    assign ram_rw     = r_ram_rw;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

    // Pick out the addressed lane and extend it. Size 11 counts as a word.
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Put the store data into the addressed byte or halfword lane of the word read back.
    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (size == 2'b00)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else if (lane[1])
            r[31:16] = wd;
        else
            r[15:0] = wd;
        return r;
    endfunction

    // Each output is registered. The value loaded at an edge is the value
    // for the state being entered.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_lat_cnt;
        w_nxt_en        = 1'b0;
        w_nxt_rw        = r_ram_rw;
        w_nxt_addr      = r_ram_addr;
        w_nxt_wdata     = r_ram_wdata;
        w_nxt_rsp_valid = 1'b0;
        w_nxt_rsp_err   = 1'b0;
        w_nxt_rsp_rdata = r_rsp_rdata;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    if (w_misalign) begin
                        w_nxt_state     = c_ST_ERR;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_err   = 1'b1;
                    end else begin
                        w_nxt_state = c_ST_SETUP;
                        w_nxt_addr  = 32'(req_addr[ADDR_W+1:2]);
                        // Only a full-word store skips the read.
                        w_nxt_rw    = ~(req_write & req_size[1]);
                        if (req_write & req_size[1])
                            w_nxt_wdata = req_wdata;
                    end
                end
            end
            c_ST_SETUP: begin
                w_nxt_en = 1'b1;
                if (r_ram_rw) begin
                    w_nxt_state = c_ST_RD;
                    w_nxt_cnt   = c_LAT_INIT;
                end else begin
                    w_nxt_state = c_ST_WR;
                end
            end
            c_ST_RD: begin
                if (r_lat_cnt == 3'd0) begin
                    if (r_write) begin
                        w_nxt_state = c_ST_MERGE;
                        w_nxt_rw    = 1'b0;
                        w_nxt_wdata = f_merge(ram_rdata, r_size, r_lane, r_wdata_lo);
                    end else begin
                        w_nxt_state     = c_ST_RESP;
                        w_nxt_rsp_valid = 1'b1;
                        w_nxt_rsp_rdata = f_extract(ram_rdata, r_size, r_lane, r_signed);
                    end
                end else begin
                    w_nxt_en  = 1'b1;
                    w_nxt_cnt = r_lat_cnt - 3'd1;
                end
            end
            c_ST_MERGE: begin
                w_nxt_state = c_ST_WR;
                w_nxt_en    = 1'b1;
            end
            c_ST_WR: begin
                w_nxt_state     = c_ST_RESP;
                w_nxt_rw        = 1'b1;
                w_nxt_rsp_valid = 1'b1;
            end
            c_ST_RESP: w_nxt_state = c_ST_IDLE;
            c_ST_ERR:  w_nxt_state = c_ST_IDLE;
            default:   w_nxt_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_lat_cnt    <= 3'd0;
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_wdata_lo   <= 16'h0000;
            r_ram_enable <= 1'b0;
            r_ram_rw     <= 1'b1;
            r_ram_addr   <= 32'h0;
            r_ram_wdata  <= 32'h0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 32'h0;
        end else begin
            r_state      <= w_nxt_state;
            r_lat_cnt    <= w_nxt_cnt;
            r_ram_enable <= w_nxt_en;
            r_ram_rw     <= w_nxt_rw;
            r_ram_addr   <= w_nxt_addr;
            r_ram_wdata  <= w_nxt_wdata;
            r_rsp_valid  <= w_nxt_rsp_valid;
            r_rsp_err    <= w_nxt_rsp_err;
            r_rsp_rdata  <= w_nxt_rsp_rdata;
            if (w_accept) begin
                r_write    <= req_write;
                r_signed   <= req_signed;
                r_size     <= req_size;
                r_lane     <= req_addr[1:0];
                r_wdata_lo <= req_wdata[15:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_ctrl                                                |
// | Purpose  : Scoreboard bench for data_mem_ctrl. A 256x32 RAM model is      |
// |            connected to the RAM port, and a reference copy of memory is    |
// |            kept alongside it to predict load data and store results.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_mem_ctrl;

    localparam int RD_LAT = 1;
    localparam int ADDR_W = 8;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        stall, rsp_valid, rsp_err, ram_enable, ram_rw;
    logic [31:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_load = 32'h0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        stall;
        logic [7:0]  lat;
        logic [63:0] mask;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_ctrl #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read, writes on a clock edge while enabled with rw=0
    assign ram_rdata = mem[ram_addr[7:0]];
    always @(posedge clk)
        if (ram_enable && !ram_rw) mem[ram_addr[7:0]] <= ram_wdata;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] w = ref_mem[a[9:2]];
        logic [31:0] s;
        if (sz == 2'b00) begin
            s = (w >> (8 * int'(a[1:0]))) & 32'hFF;
            if (sg && s[7]) s = s | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            s = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (sg && s[15]) s = s | 32'hFFFF_0000;
        end else begin
            s = w;
        end
        return s;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int i = int'(a[9:2]);
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            ref_mem[i] = (ref_mem[i] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = 16 * int'(a[1]);
            ref_mem[i] = (ref_mem[i] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end else begin
            ref_mem[i] = wd;
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e, g;
        bit mis, got;
        int cyc;
        logic [63:0] mask;
        mis = TRAP && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
        e.err = mis;
        e.stall = mis;
        if (mis) begin
            e.lat = 8'd1; e.mask = '0;
        end else if (!wr) begin
            e.lat = 8'(2 + RD_LAT); e.mask = bits(2, 1 + RD_LAT);
            last_load = model_load(sz, sg, a);
        end else if (sz[1]) begin
            e.lat = 8'd3; e.mask = bits(2, 2);
            model_store(sz, a, wd);
        end else begin
            e.lat = 8'(4 + RD_LAT); e.mask = bits(2, 1 + RD_LAT) | bits(3 + RD_LAT, 3 + RD_LAT);
            model_store(sz, a, wd);
        end
        e.rdata = last_load;
        sb.push_back(e);

        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        #1 check_val("stall_on_req", 64'(stall), 64'd1);
        @(posedge clk);
        cyc = 0; mask = '0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ram_enable) mask[cyc] = 1'b1;
            if (rsp_valid) begin
                got = 1'b1;
                req_valid = 1'b0;
                g = sb.pop_front();
                check_val("latency", 64'(cyc), 64'(g.lat));
                check_val("rdata", 64'(rsp_rdata), 64'(g.rdata));
                check_val("err", 64'(rsp_err), 64'(g.err));
                check_val("stall_rsp", 64'(stall), 64'(g.stall));
            end
        end
        if (!got) begin
            check_val("rsp_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            void'(sb.pop_front());
        end else begin
            @(negedge clk);
            if (ram_enable) mask[cyc + 1] = 1'b1;
            check_val("enable_pattern", mask, e.mask);
            check_val("ram_word", 64'(mem[a[9:2]]), 64'(ref_mem[a[9:2]]));
        end
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA5A5_0000 + 32'(i * 32'h0101_0101);
        end
        mem[5] = 32'h8877_66F4;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        repeat (2) @(negedge clk);
        check_val("rst_enable", 64'(ram_enable), 64'd0);
        check_val("rst_rw", 64'(ram_rw), 64'd1);
        check_val("rst_addr", 64'(ram_addr), 64'd0);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rdata", 64'(rsp_rdata), 64'd0);
        reset = 1'b0;

        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check_val("word_load_val", 64'(rsp_rdata), 64'h8877_66F4);
        do_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
        check_val("byte_s_val", 64'(rsp_rdata), 64'hFFFF_FFF4);
        do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0);
        check_val("byte_s16_val", 64'(rsp_rdata), 64'h0000_0077);
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        check_val("half_s_val", 64'(rsp_rdata), 64'hFFFF_8877);
        do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
        check_val("ram8", 64'(mem[8]), 64'hDEAD_BEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h1234_56AB);
        check_val("ram5", 64'(mem[5]), 64'h8877_ABF4);
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234);
        do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_F414, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000_5555);
        do_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0);

        for (int k = 0; k < 24; k++)
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   $urandom & 32'hFFFF_FC3F, $urandom);

        // Reset while the RD state of a load is in progress
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_addr = 32'h14; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("rd_enable", 64'(ram_enable), 64'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_enable", 64'(ram_enable), 64'd0);
        check_val("mid_rst_rw", 64'(ram_rw), 64'd1);
        check_val("mid_rst_addr", 64'(ram_addr), 64'd0);
        check_val("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        check_val("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
        req_valid = 1'b0;
        last_load = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("no_rsp_after_rst", 64'(seen), 64'd0);
        do_req(1'b0, 2'b00, 1'b1, 32'h16, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
